dsp_subtractor_pipe: RTL and testbench

//  Two-stage pipelined subtractor, the counterpart of the DSP adder in the processor ALU datapath.

---
 rtl/dsp_subtractor_pipe.sv | 190 +++++++++++++++++++
 tb/tb_dsp_subtractor_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// dsp_subtractor_pipe
//   Two-stage pipelined subtractor: diff = minuend - subtrahend, computed as
//   minuend + ~subtrahend + 1 modulo 2^WIDTH.
//   The carry chain is split into two halves:
//     S1 registers the low-half sum, its carry-out, and the high halves of A and ~B.
//     S2 adds the high halves plus that carry and registers the result.
//   Valid/ready handshakes are used on both sides. Throughput is one result per
//   cycle. At most two results are held under backpressure.
//
// Parameters
//   WIDTH       operand/result width. It must be even; each half is WIDTH/2 bits.
//
// Ports
//   clk         system clock; all state updates on the rising edge
//   reset       asynchronous, active-high; clears all pipeline state
//   in_valid    operand pair present
//   in_ready    pipeline accepts an operand pair this cycle (combinational)
//   minuend     operand A
//   subtrahend  operand B
//   out_valid   result present (S2 valid bit)
//   out_ready   consumer takes the result this cycle
//   diff        A - B modulo 2^WIDTH, driven directly from an S2 register
//   flags       {zero, negative, borrow, overflow}; only with DSPSUB_FLAGS_EN
//
// Configuration
//   DSPSUB_FLAGS_EN  When defined, the flags port and its S2 register exist.
//                    When undefined, there is no flag logic at all.
// -----------------------------------------------------------------------------
module dsp_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DSPSUB_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH-1:0] diff
);

    localparam int HALF = WIDTH / 2;

`ifdef DSPSUB_FLAGS_EN
    // Status flags for branch compare: {zero, negative, borrow, overflow}.
    // borrow is the inverted final carry (A < B unsigned).
    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0] d,
        input logic             c_out,
        input logic             a_msb,
        input logic             b_msb
    );
        logic zero_f;
        logic neg_f;
        logic borrow_f;
        logic ovf_f;
        zero_f   = (d == {WIDTH{1'b0}});
        neg_f    = d[WIDTH-1];
        borrow_f = ~c_out;
        ovf_f    = (a_msb ^ b_msb) & (d[WIDTH-1] ^ a_msb);
        return {zero_f, neg_f, borrow_f, ovf_f};
    endfunction
`endif

    // S1 state
    logic            s1_valid_r;
    logic [HALF-1:0] s1_lo_sum_r;
    logic            s1_c_lo_r;
    logic [HALF-1:0] s1_a_hi_r;
    logic [HALF-1:0] s1_nb_hi_r;
`ifdef DSPSUB_FLAGS_EN
    logic            s1_a_msb_r;
    logic            s1_b_msb_r;
    logic [3:0]      s2_flags_r;
    logic            c_hi_s;
    logic [3:0]      flags_next_s;
`endif

    // S2 state
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_diff_r;

    // Combinational datapath and handshake
    logic [HALF-1:0]  lo_sum_s;
    logic             lo_c_s;
    logic [HALF-1:0]  hi_sum_s;
    logic [WIDTH-1:0] diff_next_s;
    logic             s1_load_s;
    logic             s2_load_s;

    // Handshake: S2 refills when empty or draining; in_ready never depends on in_valid.
    always_comb begin
        s2_load_s = s1_valid_r & (~s2_valid_r | out_ready);
        in_ready  = ~s1_valid_r | s2_load_s;
        s1_load_s = in_valid & in_ready;
    end

    // Low half of A + ~B + 1; the +1 enters as the low-half carry-in.
    always_comb begin
        {lo_c_s, lo_sum_s} = {1'b0, minuend[HALF-1:0]}
                           + {1'b0, ~subtrahend[HALF-1:0]}
                           + {{HALF{1'b0}}, 1'b1};
    end

`ifdef DSPSUB_FLAGS_EN
    // High half adds the registered low-half carry. The final carry feeds borrow.
    always_comb begin
        {c_hi_s, hi_sum_s} = {1'b0, s1_a_hi_r} + {1'b0, s1_nb_hi_r}
                           + {{HALF{1'b0}}, s1_c_lo_r};
        diff_next_s  = {hi_sum_s, s1_lo_sum_r};
        flags_next_s = calc_flags(diff_next_s, c_hi_s, s1_a_msb_r, s1_b_msb_r);
    end
`else
    // High half adds the registered low-half carry. The final carry is not needed.
    always_comb begin
        hi_sum_s    = s1_a_hi_r + s1_nb_hi_r + {{(HALF-1){1'b0}}, s1_c_lo_r};
        diff_next_s = {hi_sum_s, s1_lo_sum_r};
    end
`endif

    // S1 register: capture the low-half result and high-half operands on input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_lo_sum_r <= {HALF{1'b0}};
            s1_c_lo_r   <= 1'b0;
            s1_a_hi_r   <= {HALF{1'b0}};
            s1_nb_hi_r  <= {HALF{1'b0}};
`ifdef DSPSUB_FLAGS_EN
            s1_a_msb_r  <= 1'b0;
            s1_b_msb_r  <= 1'b0;
`endif
        end else begin
            if (s1_load_s) begin
                s1_valid_r  <= 1'b1;
                s1_lo_sum_r <= lo_sum_s;
                s1_c_lo_r   <= lo_c_s;
                s1_a_hi_r   <= minuend[WIDTH-1:HALF];
                s1_nb_hi_r  <= ~subtrahend[WIDTH-1:HALF];
`ifdef DSPSUB_FLAGS_EN
                s1_a_msb_r  <= minuend[WIDTH-1];
                s1_b_msb_r  <= subtrahend[WIDTH-1];
`endif
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
        end
    end

    // S2 register: load from S1 when it advances; otherwise drop valid on output transfer.
    // The result data is held unchanged while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_diff_r  <= {WIDTH{1'b0}};
`ifdef DSPSUB_FLAGS_EN
            s2_flags_r <= 4'b0000;
`endif
        end else begin
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
                s2_diff_r  <= diff_next_s;
`ifdef DSPSUB_FLAGS_EN
                s2_flags_r <= flags_next_s;
`endif
            end else if (out_ready) begin
                s2_valid_r <= 1'b0;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
        end
    end

    // Outputs come straight from S2 registers.
    always_comb begin
        out_valid = s2_valid_r;
        diff      = s2_diff_r;
`ifdef DSPSUB_FLAGS_EN
        flags     = s2_flags_r;
`endif
    end

endmodule

// File: tb/tb_dsp_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// tb_dsp_subtractor_pipe
//   Directed testbench for dsp_subtractor_pipe (WIDTH = 32).
//   Each scenario task drives stimulus and compares results against
//   hand-computed values. Flag checks are compiled in only with DSPSUB_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_dsp_subtractor_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] minuend;
    logic [31:0] subtrahend;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic [3:0]  flags_obs;

    int total_cnt = 0;
    int pass_cnt  = 0;

    dsp_subtractor_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef DSPSUB_FLAGS_EN
        .flags      (flags_obs),
`endif
        .diff       (diff)
    );

`ifndef DSPSUB_FLAGS_EN
    assign flags_obs = 4'b0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one pair with out_ready high and return what appears two cycles later.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic v, output logic [31:0] d, output logic [3:0] f);
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        out_ready  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        v = out_valid;
        d = diff;
        f = flags_obs;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        minuend    = 32'd0;
        subtrahend = 32'd0;
        out_ready  = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (diff !== 32'd0) $display("FAIL reset_diff got %h want 0", diff);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready);
        else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic v; logic [31:0] d; logic [3:0] f;
        run_one(32'd10, 32'd0, v, d, f);
        total_cnt++;
        if (v !== 1'b1) $display("FAIL lat2_valid got %0b want 1", v);
        else pass_cnt++;
        total_cnt++;
        if (d !== 32'd10) $display("FAIL sub_10_0 got %0d want 10", d);
        else pass_cnt++;
`ifdef DSPSUB_FLAGS_EN
        total_cnt++;
        if (f !== 4'b0000) $display("FAIL flags_10_0 got %b want 0000", f);
        else pass_cnt++;
`endif
        run_one(32'd1000, 32'd10, v, d, f);
        total_cnt++;
        if (d !== 32'd990) $display("FAIL sub_1000_10 got %0d want 990", d);
        else pass_cnt++;
        run_one(32'd10, 32'd10, v, d, f);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL sub_10_10 got %0d want 0", d);
        else pass_cnt++;
`ifdef DSPSUB_FLAGS_EN
        total_cnt++;
        if (f !== 4'b1000) $display("FAIL flags_zero got %b want 1000", f);
        else pass_cnt++;
`endif
        // Borrow must ripple across the half boundary.
        run_one(32'h0001_0000, 32'd1, v, d, f);
        total_cnt++;
        if (d !== 32'h0000_FFFF) $display("FAIL sub_half_borrow got %h want 0000ffff", d);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic v; logic [31:0] d; logic [3:0] f;
        run_one(32'd0, 32'd1, v, d, f);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL sub_0_1 got %h want ffffffff", d);
        else pass_cnt++;
`ifdef DSPSUB_FLAGS_EN
        total_cnt++;
        if (f !== 4'b0110) $display("FAIL flags_0_1 got %b want 0110", f);
        else pass_cnt++;
`endif
        run_one(32'h8000_0000, 32'd1, v, d, f);
        total_cnt++;
        if (d !== 32'h7FFF_FFFF) $display("FAIL sub_min_1 got %h want 7fffffff", d);
        else pass_cnt++;
`ifdef DSPSUB_FLAGS_EN
        total_cnt++;
        if (f !== 4'b0001) $display("FAIL flags_ovf got %b want 0001", f);
        else pass_cnt++;
`endif
        // Let the last result drain.
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [5] = '{32'd99, 32'd198, 32'd297, 32'd396, 32'd495};
        int idx      = 0;
        int rx       = 0;
        int low_cnt  = 0;
        int held_bad = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid   = (idx < 5);
            minuend    = (idx + 1) * 100;
            subtrahend = idx + 1;
            out_ready  = !(c >= 2 && c <= 4);
            #1;
            if (in_valid && !in_ready) low_cnt++;
            if (c >= 2 && c <= 4 && (out_valid !== 1'b1 || diff !== 32'd99)) held_bad++;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (rx >= 5) $display("FAIL bp_extra_result got %0d want none", diff);
                else if (diff !== exp_q[rx]) $display("FAIL bp_order[%0d] got %0d want %0d", rx, diff, exp_q[rx]);
                else pass_cnt++;
                rx++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (rx !== 5) $display("FAIL bp_count got %0d want 5", rx);
        else pass_cnt++;
        total_cnt++;
        if (low_cnt !== 3) $display("FAIL bp_in_ready_low got %0d want 3", low_cnt);
        else pass_cnt++;
        total_cnt++;
        if (held_bad !== 0) $display("FAIL bp_held_stable got %0d want 0", held_bad);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drained got %0b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        int          cnt   = 0;
        logic [31:0] first = 32'd0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        minuend    = 32'd50;
        subtrahend = 32'd1;
        step();
        minuend    = 32'd60;
        subtrahend = 32'd2;
        step();
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL rst_full got valid=%0b ready=%0b want 1/0", out_valid, in_ready);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_async_valid got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (diff !== 32'd0) $display("FAIL rst_async_diff got %h want 0", diff);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_async_ready got %0b want 1", in_ready);
        else pass_cnt++;
        step();
        reset      = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        minuend    = 32'd7;
        subtrahend = 32'd3;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid) begin
                if (cnt == 0) first = diff;
                cnt++;
            end
            step();
        end
        total_cnt++;
        if (cnt !== 1) $display("FAIL rst_out_count got %0d want 1", cnt);
        else pass_cnt++;
        total_cnt++;
        if (first !== 32'd4) $display("FAIL rst_first_diff got %0d want 4", first);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
